// File: rtl/multicore_pkg.sv
// Shared types and default widths for the multicore result collector and the jimmy/memory tops.
package multicore_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} collector_state_e;

  localparam int CORE_DONE_BIT = 2;
  localparam int DEF_NUM_CORES = 2;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_STROBE_W  = 4;
  localparam int DEF_CNT_W     = 32;
  localparam int DEF_TIMEOUT   = 50000;

endpackage

// File: rtl/core_done_tracker.sv
// Per-core completion tracker: falling-edge detect on the done strobe, sticky done bit and result capture.
module core_done_tracker #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              strobe,
  input  logic [DATA_W-1:0] result,
  output logic              done,
  output logic [DATA_W-1:0] data
);

  logic prev;
  logic fire;

  // prev clears in reset, so a strobe high at release must be seen once before it can fall
  assign fire = prev & ~strobe & ~done & run;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
      done <= 1'b0;
      data <= '0;
    end else begin
      prev <= strobe;
      if (fire) begin
        done <= 1'b1;
        data <= result;
      end
    end
  end

endmodule

// File: rtl/multicore_result_collector.sv
// Collects per-core results on done-strobe falling edges, counts run cycles, then streams results out.
// Optional COLLECTOR_TIMEOUT_EN adds a sticky timeout_o that forces the drain after TIMEOUT cycles.
module multicore_result_collector
  import multicore_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int STROBE_W  = DEF_STROBE_W,
  parameter int DONE_BIT  = CORE_DONE_BIT,
  parameter int CNT_W     = DEF_CNT_W,
`ifdef COLLECTOR_TIMEOUT_EN
  parameter int TIMEOUT   = DEF_TIMEOUT,
`endif
  localparam int IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES*STROBE_W-1:0] strobe_i,
  input  logic [NUM_CORES*DATA_W-1:0]   result_i,
  output logic [NUM_CORES-1:0]          core_done_o,
  output logic                          all_done_o,
  output logic [CNT_W-1:0]              cycles_o,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [IDX_W-1:0]              res_idx_o,
  output logic [DATA_W-1:0]             res_data_o,
  output logic                          drained_o
`ifdef COLLECTOR_TIMEOUT_EN
  , output logic                        timeout_o
`endif
);

  collector_state_e                 state, state_nxt;
  logic [CNT_W-1:0]                 cnt_nxt;
  logic [IDX_W-1:0]                 idx_nxt;
  logic [NUM_CORES-1:0][DATA_W-1:0] cap;
  logic                             run;
  logic                             unused_strobe;

  assign run           = (state == RUN);
  assign unused_strobe = ^strobe_i;

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    core_done_tracker #(.DATA_W(DATA_W)) u_trk (
      .clk    (clk),
      .reset  (reset),
      .run    (run),
      .strobe (strobe_i[k*STROBE_W+DONE_BIT]),
      .result (result_i[k*DATA_W +: DATA_W]),
      .done   (core_done_o[k]),
      .data   (cap[k])
    );
  end

  assign all_done_o  = (state != RUN);
  assign res_valid_o = (state == DRAIN);
  assign drained_o   = (state == DONE);
  assign res_data_o  = cap[res_idx_o];

`ifdef COLLECTOR_TIMEOUT_EN
  logic to_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cycles_o;
    idx_nxt   = res_idx_o;
`ifdef COLLECTOR_TIMEOUT_EN
    to_nxt    = timeout_o;
`endif
    case (state)
      RUN: begin
        // the edge that captures the last core still counts; the FSM leaves on the following edge
        if (&core_done_o) begin
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = (&cycles_o) ? cycles_o : cycles_o + 1'b1;
`ifdef COLLECTOR_TIMEOUT_EN
          if (cnt_nxt >= CNT_W'(TIMEOUT)) begin
            to_nxt    = 1'b1;
            state_nxt = DRAIN;
          end
`endif
        end
      end
      DRAIN: begin
        if (res_ready_i) begin
          if (res_idx_o == IDX_W'(NUM_CORES-1)) state_nxt = DONE;
          else                                  idx_nxt   = res_idx_o + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      cycles_o  <= '0;
      res_idx_o <= '0;
`ifdef COLLECTOR_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cycles_o  <= cnt_nxt;
      res_idx_o <= idx_nxt;
`ifdef COLLECTOR_TIMEOUT_EN
      timeout_o <= to_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_multicore_result_collector.sv
// Directed bench for multicore_result_collector (NUM_CORES=2, DATA_W=8, STROBE_W=4, DONE_BIT=2).
module tb_multicore_result_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  strobe_i;
  logic [15:0] result_i;
  logic [1:0]  core_done_o;
  logic        all_done_o;
  logic [31:0] cycles_o;
  logic        res_valid_o;
  logic        res_ready_i;
  logic        res_idx_o;
  logic [7:0]  res_data_o;
  logic        drained_o;
`ifdef COLLECTOR_TIMEOUT_EN
  logic        timeout_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef COLLECTOR_TIMEOUT_EN
  multicore_result_collector #(.TIMEOUT(100)) dut (
`else
  multicore_result_collector dut (
`endif
    .clk(clk), .reset(reset), .strobe_i(strobe_i), .result_i(result_i),
    .core_done_o(core_done_o), .all_done_o(all_done_o), .cycles_o(cycles_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_idx_o(res_idx_o),
    .res_data_o(res_data_o), .drained_o(drained_o)
`ifdef COLLECTOR_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  typedef struct {
    logic        rst;
    logic [7:0]  stb;
    logic [15:0] res;
    logic        rdy;
    logic [1:0]  cd;
    logic        ad;
    logic        vld;
    logic        idx;
    logic [7:0]  dat;
    logic        drn;
    logic [31:0] cyc;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [7:0] stb(input logic s0, input logic s1);
    return {1'b0, s1, 2'b00, 1'b0, s0, 2'b00};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] cd, input logic ad, input logic vld,
                         input logic idx, input logic [7:0] dat, input logic drn, input logic [31:0] cyc);
    check({tag, " core_done"}, 32'(core_done_o), 32'(cd));
    check({tag, " all_done"},  32'(all_done_o),  32'(ad));
    check({tag, " valid"},     32'(res_valid_o), 32'(vld));
    check({tag, " idx"},       32'(res_idx_o),   32'(idx));
    check({tag, " data"},      32'(res_data_o),  32'(dat));
    check({tag, " drained"},   32'(drained_o),   32'(drn));
    check({tag, " cycles"},    cycles_o,         cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; strobe_i = '0; result_i = '0; res_ready_i = 1'b0;

    // simultaneous falls on both cores, then a ready-high stream
    tbl[0] = '{1'b1, 8'h00, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0};
    tbl[1] = '{1'b1, 8'h00, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0};
    tbl[2] = '{1'b0, 8'h44, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 32'd1};
    tbl[3] = '{1'b0, 8'h00, 16'h0907, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'd7, 1'b0, 32'd2};
    tbl[4] = '{1'b0, 8'h00, 16'h0000, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 8'd7, 1'b0, 32'd2};
    tbl[5] = '{1'b0, 8'h00, 16'h0000, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 8'd9, 1'b0, 32'd2};
    tbl[6] = '{1'b0, 8'h00, 16'h0000, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 8'd9, 1'b1, 32'd2};
    tbl[7] = '{1'b0, 8'h44, 16'h3333, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 8'd9, 1'b1, 32'd2};
    tbl[8] = '{1'b0, 8'h00, 16'h3333, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 8'd9, 1'b1, 32'd2};

    for (int i = 0; i < 9; i++) begin
      reset = tbl[i].rst; strobe_i = tbl[i].stb; result_i = tbl[i].res; res_ready_i = tbl[i].rdy;
      step();
      chk_all($sformatf("tbl%0d", i), tbl[i].cd, tbl[i].ad, tbl[i].vld, tbl[i].idx,
              tbl[i].dat, tbl[i].drn, tbl[i].cyc);
    end

    // core0 falls at cycle 10 (42), core1 at cycle 30 (200)
    res_ready_i = 1'b0; strobe_i = '0; result_i = '0;
    do_reset();
    for (int c = 1; c <= 31; c++) begin
      strobe_i = stb(c == 9, c == 29);
      result_i = {(c == 30) ? 8'd200 : 8'h55, (c == 10) ? 8'd42 : 8'h55};
      step();
      if (c == 9)  check("t1 cd@9", 32'(core_done_o), 32'd0);
      if (c == 10) chk_all("t1 c10", 2'b01, 1'b0, 1'b0, 1'b0, 8'd42, 1'b0, 32'd10);
      if (c == 30) chk_all("t1 c30", 2'b11, 1'b0, 1'b0, 1'b0, 8'd42, 1'b0, 32'd30);
      if (c == 31) chk_all("t1 c31", 2'b11, 1'b1, 1'b1, 1'b0, 8'd42, 1'b0, 32'd30);
    end

    // backpressure for 3 cycles with a core0 re-pulse carrying 99
    for (int c = 0; c < 3; c++) begin
      strobe_i = stb(c == 0, 1'b0);
      result_i = {8'd99, 8'd99};
      step();
      chk_all($sformatf("t3 hold%0d", c), 2'b11, 1'b1, 1'b1, 1'b0, 8'd42, 1'b0, 32'd30);
    end
    res_ready_i = 1'b1;
    step();
    chk_all("t3 beat1", 2'b11, 1'b1, 1'b1, 1'b1, 8'd200, 1'b0, 32'd30);
    step();
    chk_all("t3 drained", 2'b11, 1'b1, 1'b0, 1'b1, 8'd200, 1'b1, 32'd30);
    res_ready_i = 1'b0;

    // strobes high across reset release: core0 falls 2 cycles later, core1 falls on the first edge only
    strobe_i = stb(1'b1, 1'b1); result_i = '0;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      strobe_i = stb(c <= 2, 1'b0);
      result_i = {8'h77, (c == 3) ? 8'h21 : 8'h77};
      step();
      if (c == 2) check("t4 cd@2", 32'(core_done_o), 32'd0);
      if (c == 3) check("t4 cd@3", 32'(core_done_o), 32'b01);
    end
    chk_all("t4 c20", 2'b01, 1'b0, 1'b0, 1'b0, 8'h21, 1'b0, 32'd20);

    // finish core1, enter DRAIN, accept one beat, then reset mid-drain
    strobe_i = stb(1'b0, 1'b1); step();
    strobe_i = '0; result_i = 16'h6600; step();
    check("t5 cd@22", 32'(core_done_o), 32'b11);
    step();
    chk_all("t5 drain", 2'b11, 1'b1, 1'b1, 1'b0, 8'h21, 1'b0, 32'd22);
    res_ready_i = 1'b1; step();
    chk_all("t5 beat1", 2'b11, 1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 32'd22);
    reset = 1'b1; res_ready_i = 1'b0; step();
    chk_all("t5 reset", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'd0);
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      strobe_i = stb(c == 2, c == 4);
      result_i = {(c == 5) ? 8'h22 : 8'hEE, (c == 3) ? 8'h11 : 8'hEE};
      step();
    end
    chk_all("t5 rerun", 2'b11, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 32'd5);
    res_ready_i = 1'b1; step();
    chk_all("t5 rerun b1", 2'b11, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 32'd5);
    step();
    chk_all("t5 rerun end", 2'b11, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 32'd5);
    res_ready_i = 1'b0;

`ifdef COLLECTOR_TIMEOUT_EN
    // only core0 finishes; the timeout forces the drain at cycle 100
    strobe_i = '0; result_i = '0;
    do_reset();
    for (int c = 1; c <= 100; c++) begin
      strobe_i = stb(c == 3, 1'b0);
      result_i = {8'h44, (c == 4) ? 8'd5 : 8'h44};
      step();
      if (c == 99) begin
        check("t6 to@99", 32'(timeout_o), 32'd0);
        check("t6 ad@99", 32'(all_done_o), 32'd0);
      end
    end
    check("t6 to@100", 32'(timeout_o), 32'd1);
    chk_all("t6 c100", 2'b01, 1'b1, 1'b1, 1'b0, 8'd5, 1'b0, 32'd100);
    res_ready_i = 1'b1; step();
    chk_all("t6 beat1", 2'b01, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 32'd100);
    step();
    chk_all("t6 end", 2'b01, 1'b1, 1'b0, 1'b1, 8'd0, 1'b1, 32'd100);
    check("t6 to sticky", 32'(timeout_o), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
